// File: rtl/dm_load_controller_if.sv
// MEM-stage load request, DM read port and writeback bundle for dm_load_controller.
interface dm_load_controller_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              i_valid;
  logic              i_ld;
  logic [ADDR_W-1:0] i_addr;
  logic [1:0]        i_unit;
  logic              i_unsigned;
  logic [4:0]        i_rd;
  logic              i_flush;
  logic              o_dm_rd_en;
  logic [ADDR_W-1:0] o_dm_addr;
  logic              i_dm_rvalid;
  logic [63:0]       i_dm_rdata;
  logic              o_stall;
  logic              o_wb_valid;
  logic [63:0]       o_wb_data;
  logic [4:0]        o_wb_rd;
  logic              o_miss_aligned_error;

  modport master (
    output i_valid, i_ld, i_addr, i_unit, i_unsigned, i_rd, i_flush,
    output i_dm_rvalid, i_dm_rdata,
    input  o_dm_rd_en, o_dm_addr, o_stall, o_wb_valid, o_wb_data, o_wb_rd,
    input  o_miss_aligned_error
  );

  modport slave (
    input  i_valid, i_ld, i_addr, i_unit, i_unsigned, i_rd, i_flush,
    input  i_dm_rvalid, i_dm_rdata,
    output o_dm_rd_en, o_dm_addr, o_stall, o_wb_valid, o_wb_data, o_wb_rd,
    output o_miss_aligned_error
  );
endinterface

// File: rtl/dm_load_controller.sv
// Load path to the 64-bit data memory: line-aligned read, lane extraction,
// sign/zero extension and a single-cycle writeback pulse.
module dm_load_controller #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned XLEN   = 64
) (
  input logic                 clk,
  input logic                 rst,
  dm_load_controller_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

  state_e            state_q, state_d;
  logic              drop_q, drop_d;
  logic [2:0]        off_q, off_d;
  logic [1:0]        unit_q, unit_d;
  logic              uns_q, uns_d;
  logic [4:0]        rd_q, rd_d;
  logic [ADDR_W-1:0] line_q, line_d;
  logic [XLEN-1:0]   data_q, data_d;

  logic              req_ld;
  logic              misaligned;
  logic              accept;
  logic              own_rvalid;
  logic [63:0]       shifted;
  logic [XLEN-1:0]   extracted;

  // Only accesses that would cross the 8-byte line are misaligned.
  always_comb begin
    misaligned = 1'b0;
    unique case (bus.i_unit)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = (bus.i_addr[2:0] == 3'd7);
      2'd2:    misaligned = (bus.i_addr[2:0] >= 3'd5);
      default: misaligned = (bus.i_addr[2:0] != 3'd0);
    endcase
  end

  assign req_ld     = (state_q == S_IDLE) && bus.i_valid && bus.i_ld && !rst;
  assign accept     = req_ld && !misaligned && !bus.i_flush;
  assign own_rvalid = bus.i_dm_rvalid && !drop_q;

  assign shifted = bus.i_dm_rdata >> {off_q, 3'b000};

  always_comb begin
    extracted = '0;
    unique case (unit_q)
      2'd0:    extracted = {{56{~uns_q & shifted[7]}},  shifted[7:0]};
      2'd1:    extracted = {{48{~uns_q & shifted[15]}}, shifted[15:0]};
      2'd2:    extracted = {{32{~uns_q & shifted[31]}}, shifted[31:0]};
      default: extracted = bus.i_dm_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    off_d   = off_q;
    unit_d  = unit_q;
    uns_d   = uns_q;
    rd_d    = rd_q;
    line_d  = line_q;
    data_d  = data_q;

    // A stale response is consumed in whatever state it shows up.
    if (bus.i_dm_rvalid && drop_q) begin
      drop_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          off_d   = bus.i_addr[2:0];
          unit_d  = bus.i_unit;
          uns_d   = bus.i_unsigned;
          rd_d    = bus.i_rd;
          line_d  = {bus.i_addr[ADDR_W-1:3], 3'b000};
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        state_d = bus.i_flush ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (bus.i_flush) begin
          state_d = S_IDLE;
          // Our read is still outstanding unless its data arrived this cycle.
          if (!own_rvalid) begin
            drop_d = 1'b1;
          end
        end else if (own_rvalid) begin
          data_d  = extracted;
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      drop_q  <= 1'b0;
      off_q   <= '0;
      unit_q  <= '0;
      uns_q   <= 1'b0;
      rd_q    <= '0;
      line_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      off_q   <= off_d;
      unit_q  <= unit_d;
      uns_q   <= uns_d;
      rd_q    <= rd_d;
      line_q  <= line_d;
      data_q  <= data_d;
    end
  end

  assign bus.o_dm_rd_en           = (state_q == S_REQ) && !bus.i_flush && !rst;
  assign bus.o_dm_addr            = (state_q == S_REQ && !rst) ? line_q : '0;
  assign bus.o_stall              = ((state_q == S_REQ || state_q == S_WAIT) && !rst) || accept;
  assign bus.o_wb_valid           = (state_q == S_RESP) && !bus.i_flush && !rst;
  assign bus.o_wb_data            = (state_q == S_RESP && !rst) ? data_q : '0;
  assign bus.o_wb_rd              = (state_q == S_RESP && !rst) ? rd_q : '0;
  assign bus.o_miss_aligned_error = req_ld && misaligned;

endmodule

// File: tb/tb_dm_load_controller.sv
// Self-checking bench for dm_load_controller: directed scenarios plus random loads
// checked against a byte-level reference model.
module tb_dm_load_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec  = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  dm_load_controller_if #(.ADDR_W(32)) bus ();

  dm_load_controller #(.ADDR_W(32), .XLEN(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: gather the addressed bytes one at a time, then extend.
  function automatic logic [63:0] ref_load(input logic [63:0] line, input logic [2:0] off,
                                           input logic [1:0] unit, input logic uns);
    int unsigned n;
    logic [63:0] v;
    logic [7:0]  b;
    n = 1 << unit;
    v = '0;
    for (int unsigned i = 0; i < n; i++) begin
      b = line[8*(off+i) +: 8];
      v = v | (64'(b) << (8*i));
    end
    if (!uns && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
    return v;
  endfunction

  function automatic logic ref_misaligned(input logic [2:0] off, input logic [1:0] unit);
    return (int'(off) + (1 << unit)) > 8;
  endfunction

  function automatic logic [104:0] all_outs();
    return {bus.o_dm_rd_en, bus.o_dm_addr, bus.o_stall, bus.o_wb_valid,
            bus.o_wb_data, bus.o_wb_rd, bus.o_miss_aligned_error};
  endfunction

  task automatic idle_inputs();
    bus.i_valid = 0; bus.i_ld = 0; bus.i_addr = '0; bus.i_unit = '0;
    bus.i_unsigned = 0; bus.i_rd = '0; bus.i_flush = 0;
    bus.i_dm_rvalid = 0; bus.i_dm_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [31:0] addr, input logic [1:0] unit,
                           input logic uns, input logic [4:0] rd);
    bus.i_valid = 1; bus.i_ld = 1; bus.i_addr = addr; bus.i_unit = unit;
    bus.i_unsigned = uns; bus.i_rd = rd;
  endtask

  // Full transaction from request to writeback; rvalid arrives lat cycles after rd_en.
  task automatic run_load(input logic [31:0] addr, input logic [1:0] unit, input logic uns,
                          input logic [4:0] rd, input logic [63:0] rdata, input int unsigned lat);
    logic        mis;
    logic [63:0] exp;
    mis = ref_misaligned(addr[2:0], unit);
    exp = ref_load(rdata, addr[2:0], unit, uns);
    drive_req(addr, unit, uns, rd);
    #1;
    vec++; if (bus.o_miss_aligned_error !== mis) begin errs++;
      $display("FAIL misalign addr=%h unit=%0d: got %b expected %b", addr, unit, bus.o_miss_aligned_error, mis); end
    vec++; if (bus.o_stall !== !mis) begin errs++;
      $display("FAIL accept_stall addr=%h: got %b expected %b", addr, bus.o_stall, !mis); end
    tick();
    bus.i_valid = 0; bus.i_ld = 0;
    #1;
    if (mis) begin
      vec++; if ({bus.o_dm_rd_en, bus.o_stall, bus.o_wb_valid} !== 3'b000) begin errs++;
        $display("FAIL misaligned_idle addr=%h: got rd_en/stall/wb=%b expected 000", addr,
                 {bus.o_dm_rd_en, bus.o_stall, bus.o_wb_valid}); end
      return;
    end
    vec++; if (bus.o_dm_rd_en !== 1'b1 || bus.o_dm_addr !== {addr[31:3], 3'b000}) begin errs++;
      $display("FAIL req rd_en/addr: got %b/%h expected 1/%h", bus.o_dm_rd_en, bus.o_dm_addr, {addr[31:3], 3'b000}); end
    for (int unsigned k = 1; k < lat; k++) begin
      tick(); #1;
      vec++; if ({bus.o_dm_rd_en, bus.o_stall, bus.o_wb_valid} !== 3'b010) begin errs++;
        $display("FAIL wait_cycle: got rd_en/stall/wb=%b expected 010", {bus.o_dm_rd_en, bus.o_stall, bus.o_wb_valid}); end
    end
    tick();
    bus.i_dm_rvalid = 1; bus.i_dm_rdata = rdata;
    #1;
    vec++; if ({bus.o_stall, bus.o_wb_valid} !== 2'b10) begin errs++;
      $display("FAIL rvalid_cycle: got stall/wb=%b expected 10", {bus.o_stall, bus.o_wb_valid}); end
    tick();
    bus.i_dm_rvalid = 0; bus.i_dm_rdata = {$urandom, $urandom};
    #1;
    vec++; if (bus.o_wb_valid !== 1'b1 || bus.o_wb_data !== exp || bus.o_wb_rd !== rd || bus.o_stall !== 1'b0) begin errs++;
      $display("FAIL writeback addr=%h unit=%0d uns=%b: got v=%b d=%h rd=%0d st=%b expected 1 %h %0d 0",
               addr, unit, uns, bus.o_wb_valid, bus.o_wb_data, bus.o_wb_rd, bus.o_stall, exp, rd); end
    tick(); #1;
    vec++; if ({bus.o_wb_valid, bus.o_stall} !== 2'b00) begin errs++;
      $display("FAIL post_wb: got wb/stall=%b expected 00", {bus.o_wb_valid, bus.o_stall}); end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick();
    drive_req(32'h0000_1000, 2'd0, 1'b0, 5'd1);
    #1;
    vec++; if (all_outs() !== '0) begin errs++;
      $display("FAIL reset_outputs: got %h expected 0", all_outs()); end
    tick();
    rst = 0; idle_inputs();
    #1;
    vec++; if (all_outs() !== '0) begin errs++;
      $display("FAIL after_reset_outputs: got %h expected 0", all_outs()); end
    tick(); #1;
    vec++; if (all_outs() !== '0) begin errs++;
      $display("FAIL no_accept_in_reset: got %h expected 0", all_outs()); end
  endtask

  task automatic test_extract();
    do_reset();
    run_load(32'h0000_1003, 2'd0, 1'b0, 5'd9,  64'h00000000_80000000, 2);
    run_load(32'h0000_2004, 2'd2, 1'b1, 5'd10, 64'h89ABCDEF_01234567, 1);
    run_load(32'h0000_2004, 2'd2, 1'b0, 5'd11, 64'h89ABCDEF_01234567, 3);
    run_load(32'h0000_0010, 2'd3, 1'b0, 5'd12, 64'h11223344_55667788, 2);
    run_load(32'h0000_0016, 2'd1, 1'b0, 5'd13, 64'h8001_0000_0000_0000, 1);
  endtask

  task automatic test_misaligned();
    do_reset();
    run_load(32'h0000_0007, 2'd1, 1'b0, 5'd1, 64'h0, 1);
    run_load(32'h0000_0006, 2'd2, 1'b0, 5'd2, 64'h0, 1);
    run_load(32'h0000_0004, 2'd3, 1'b0, 5'd3, 64'h0, 1);
    run_load(32'h0000_0007, 2'd0, 1'b0, 5'd4, 64'h5A00_0000_0000_0000, 1);
  endtask

  task automatic test_flush_wait();
    do_reset();
    drive_req(32'h0000_0008, 2'd0, 1'b0, 5'd3);
    tick(); bus.i_valid = 0; bus.i_ld = 0;
    tick(); bus.i_flush = 1; #1;
    vec++; if ({bus.o_stall, bus.o_wb_valid} !== 2'b10) begin errs++;
      $display("FAIL flush_wait_cycle: got stall/wb=%b expected 10", {bus.o_stall, bus.o_wb_valid}); end
    tick(); bus.i_flush = 0;
    drive_req(32'h0000_0000, 2'd0, 1'b0, 5'd7); #1;
    vec++; if (bus.o_stall !== 1'b1) begin errs++;
      $display("FAIL accept_with_drop: got stall %b expected 1", bus.o_stall); end
    tick(); bus.i_valid = 0; bus.i_ld = 0;
    tick(); bus.i_dm_rvalid = 1; bus.i_dm_rdata = 64'hFF;
    tick(); bus.i_dm_rvalid = 0; #1;
    vec++; if ({bus.o_wb_valid, bus.o_stall} !== 2'b01) begin errs++;
      $display("FAIL stale_dropped: got wb/stall=%b expected 01", {bus.o_wb_valid, bus.o_stall}); end
    bus.i_dm_rvalid = 1; bus.i_dm_rdata = 64'h7F;
    tick(); bus.i_dm_rvalid = 0; #1;
    vec++; if (bus.o_wb_valid !== 1'b1 || bus.o_wb_data !== ref_load(64'h7F, 3'd0, 2'd0, 1'b0) || bus.o_wb_rd !== 5'd7) begin errs++;
      $display("FAIL real_after_stale: got v=%b d=%h rd=%0d expected 1 %h 7", bus.o_wb_valid, bus.o_wb_data,
               bus.o_wb_rd, ref_load(64'h7F, 3'd0, 2'd0, 1'b0)); end
    tick(); #1;
    vec++; if (bus.o_wb_valid !== 1'b0) begin errs++;
      $display("FAIL single_wb: got %b expected 0", bus.o_wb_valid); end
    run_load(32'h0000_0020, 2'd3, 1'b0, 5'd8, 64'hCAFE_F00D_DEAD_BEEF, 1);
  endtask

  task automatic test_flush_other();
    do_reset();
    // Flush in REQ: no read issued, nothing left outstanding.
    drive_req(32'h0000_0010, 2'd3, 1'b0, 5'd5);
    tick(); bus.i_valid = 0; bus.i_ld = 0; bus.i_flush = 1; #1;
    vec++; if (bus.o_dm_rd_en !== 1'b0) begin errs++;
      $display("FAIL flush_req_rd_en: got %b expected 0", bus.o_dm_rd_en); end
    tick(); bus.i_flush = 0; #1;
    vec++; if (bus.o_stall !== 1'b0) begin errs++;
      $display("FAIL flush_req_idle: got stall %b expected 0", bus.o_stall); end
    run_load(32'h0000_0030, 2'd1, 1'b1, 5'd6, 64'h0000_0000_ABCD_0000, 1);
    // Flush coinciding with our own rvalid: data discarded, no drop pending.
    drive_req(32'h0000_0040, 2'd2, 1'b0, 5'd7);
    tick(); bus.i_valid = 0; bus.i_ld = 0;
    tick(); bus.i_flush = 1; bus.i_dm_rvalid = 1; bus.i_dm_rdata = 64'h1;
    tick(); bus.i_flush = 0; bus.i_dm_rvalid = 0; #1;
    vec++; if ({bus.o_wb_valid, bus.o_stall} !== 2'b00) begin errs++;
      $display("FAIL flush_rvalid_same: got wb/stall=%b expected 00", {bus.o_wb_valid, bus.o_stall}); end
    run_load(32'h0000_0048, 2'd0, 1'b1, 5'd9, 64'h0000_0000_0000_00C3, 2);
    // Flush in RESP suppresses the writeback.
    drive_req(32'h0000_0050, 2'd3, 1'b0, 5'd10);
    tick(); bus.i_valid = 0; bus.i_ld = 0;
    tick(); bus.i_dm_rvalid = 1; bus.i_dm_rdata = 64'h55;
    tick(); bus.i_dm_rvalid = 0; bus.i_flush = 1; #1;
    vec++; if (bus.o_wb_valid !== 1'b0) begin errs++;
      $display("FAIL flush_resp: got wb %b expected 0", bus.o_wb_valid); end
    tick(); bus.i_flush = 0; #1;
    vec++; if ({bus.o_wb_valid, bus.o_stall} !== 2'b00) begin errs++;
      $display("FAIL after_flush_resp: got wb/stall=%b expected 00", {bus.o_wb_valid, bus.o_stall}); end
  endtask

  task automatic test_rst_in_wait();
    do_reset();
    drive_req(32'h0000_0100, 2'd3, 1'b0, 5'd15);
    tick(); bus.i_valid = 0; bus.i_ld = 0;
    tick(); rst = 1;
    tick(); rst = 0; #1;
    vec++; if (all_outs() !== '0) begin errs++;
      $display("FAIL rst_in_wait: got %h expected 0", all_outs()); end
    bus.i_dm_rvalid = 1; bus.i_dm_rdata = 64'hABCD;
    tick(); bus.i_dm_rvalid = 0; #1;
    vec++; if ({bus.o_wb_valid, bus.o_stall} !== 2'b00) begin errs++;
      $display("FAIL stray_rvalid: got wb/stall=%b expected 00", {bus.o_wb_valid, bus.o_stall}); end
    run_load(32'h0000_0108, 2'd1, 1'b0, 5'd16, 64'h0000_0000_0000_F00F, 1);
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 60; i++) begin
      bus.i_valid = 1'($urandom); bus.i_ld = ~bus.i_valid; bus.i_addr = $urandom;
      #1;
      vec++; if (all_outs() !== '0) begin errs++;
        $display("FAIL idle_noise: got %h expected 0", all_outs()); end
      run_load($urandom, 2'($urandom), 1'($urandom), 5'($urandom), {$urandom, $urandom},
               $urandom_range(1, 4));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_extract();
    test_misaligned();
    test_flush_wait();
    test_flush_other();
    test_rst_in_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
